// File: rtl/regfile_write_queue.sv
// Write-side front end for the 32x32 register file.
// Buffers (register, data) write requests in a small FIFO, drains one entry per cycle
// into the single write port, and forwards the youngest pending data to both readers.
module regfile_write_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_reg,
  input  logic [DW-1:0]            in_data,
  input  logic                     port_free,
  output logic                     RegWriteEN,
  output logic [AW-1:0]            WriteReg,
  output logic [DW-1:0]            WriteData,
  input  logic [AW-1:0]            ReadReg1,
  input  logic [AW-1:0]            ReadReg2,
  output logic                     fwd_hit1,
  output logic [DW-1:0]            fwd_data1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_COUNT = DEPTH[PW:0];
  localparam logic [PW:0]   CNT_ONE    = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE    = PW'(1);

  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [DEPTH-1:0] entryValid;
  logic [AW-1:0]    entryReg  [DEPTH];
  logic [DW-1:0]    entryData [DEPTH];

  logic accept;
  logic store;
  logic retire;
  logic [PW-1:0] idx;

  // Handshake and drain decisions come from registered count only.
  assign in_ready   = (count != FULL_COUNT);
  assign accept     = in_valid && in_ready;
  // Writes to r0 complete the handshake but are discarded.
  assign store      = accept && (in_reg != '0);
  assign RegWriteEN = port_free && (count != '0);
  assign retire     = RegWriteEN;

  // Pointers, occupancy and per-entry valid bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      count      <= '0;
      entryValid <= '0;
    end else begin
      if (store) begin
        wrPtr             <= wrPtr + PTR_ONE;
        entryValid[wrPtr] <= 1'b1;
      end
      // Store and retire never target the same slot: retire needs count != 0 and store
      // needs count != DEPTH, so wrPtr != rdPtr whenever both fire.
      if (retire) begin
        rdPtr             <= rdPtr + PTR_ONE;
        entryValid[rdPtr] <= 1'b0;
      end
      case ({store, retire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: ;
      endcase
    end
  end

  // Entry payload storage; validity is tracked separately so no reset is needed here.
  always_ff @(posedge clk) begin
    if (store) begin
      entryReg[wrPtr]  <= in_reg;
      entryData[wrPtr] <= in_data;
    end
  end

  // Head entry drives the register-file write port; zero when empty.
  always_comb begin
    WriteReg  = '0;
    WriteData = '0;
    if (count != '0) begin
      WriteReg  = entryReg[rdPtr];
      WriteData = entryData[rdPtr];
    end
  end

  // Bypass: walk oldest to youngest so the youngest match wins.
  always_comb begin
    fwd_hit1  = 1'b0;
    fwd_data1 = '0;
    fwd_hit2  = 1'b0;
    fwd_data2 = '0;
    idx       = rdPtr;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr + PW'(i);
      if (entryValid[idx] && (ReadReg1 != '0) && (entryReg[idx] == ReadReg1)) begin
        fwd_hit1  = 1'b1;
        fwd_data1 = entryData[idx];
      end
      if (entryValid[idx] && (ReadReg2 != '0) && (entryReg[idx] == ReadReg2)) begin
        fwd_hit2  = 1'b1;
        fwd_data2 = entryData[idx];
      end
    end
  end

endmodule

// File: tb/tb_regfile_write_queue.sv
// Self-checking bench for regfile_write_queue: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_regfile_write_queue;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_reg;
  logic [31:0] in_data;
  logic        port_free;
  logic        RegWriteEN;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [4:0]  ReadReg1;
  logic [4:0]  ReadReg2;
  logic        fwd_hit1;
  logic [31:0] fwd_data1;
  logic        fwd_hit2;
  logic [31:0] fwd_data2;
  logic [2:0]  count;

  int passCnt = 0;
  int totalCnt = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;
  ent_t mq[$];

  regfile_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_reg(in_reg), .in_data(in_data),
    .port_free(port_free),
    .RegWriteEN(RegWriteEN), .WriteReg(WriteReg), .WriteData(WriteData),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
    .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a plain FIFO of pending writes, youngest at the back.
  function automatic bit mhit(input logic [4:0] a);
    if (a == 0) return 1'b0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].r == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] mdata(input logic [4:0] a);
    if (a == 0) return 32'h0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].r == a) return mq[i].d;
    return 32'h0;
  endfunction

  // Advance one clock from a negedge to the next negedge, updating the model.
  task automatic step();
    bit acc, dq;
    acc = in_valid && (mq.size() != 4);
    dq  = port_free && (mq.size() != 0);
    @(posedge clk);
    if (!rst) begin
      if (dq) void'(mq.pop_front());
      if (acc && in_reg != 0) mq.push_back('{r: in_reg, d: in_data});
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    #1;
    totalCnt++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passCnt++;
    totalCnt++; if (RegWriteEN !== 1'b0) $display("FAIL reset_wen: got %b want 0", RegWriteEN); else passCnt++;
    @(negedge clk);
    rst = 1'b0;
    // Load one entry, then hit reset mid-clock.
    port_free = 1'b0; in_valid = 1'b1; in_reg = 5'd7; in_data = 32'h1234_5678;
    step();
    in_valid = 1'b0; ReadReg1 = 5'd7;
    #1;
    totalCnt++; if (fwd_hit1 !== 1'b1) $display("FAIL prereset_hit: got %b want 1", fwd_hit1); else passCnt++;
    #2;
    rst = 1'b1; mq.delete();
    #1;
    totalCnt++; if (count !== 3'd0) $display("FAIL midreset_count: got %0d want 0", count); else passCnt++;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL midreset_ready: got %b want 1", in_ready); else passCnt++;
    totalCnt++; if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'h0)
      $display("FAIL midreset_fwd: got %b/%h want 0/0", fwd_hit1, fwd_data1); else passCnt++;
    totalCnt++; if (WriteReg !== 5'd0 || WriteData !== 32'h0)
      $display("FAIL midreset_head: got %0d/%h want 0/0", WriteReg, WriteData); else passCnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single();
    port_free = 1'b1; in_valid = 1'b1; in_reg = 5'd5; in_data = 32'hDEAD_BEEF;
    step();
    in_valid = 1'b0; ReadReg1 = 5'd5;
    #1;
    totalCnt++; if (RegWriteEN !== 1'b1) $display("FAIL single_wen: got %b want 1", RegWriteEN); else passCnt++;
    totalCnt++; if (WriteReg !== 5'd5) $display("FAIL single_reg: got %0d want 5", WriteReg); else passCnt++;
    totalCnt++; if (WriteData !== 32'hDEAD_BEEF)
      $display("FAIL single_data: got %h want deadbeef", WriteData); else passCnt++;
    totalCnt++; if (fwd_hit1 !== 1'b1 || fwd_data1 !== 32'hDEAD_BEEF)
      $display("FAIL single_fwd: got %b/%h want 1/deadbeef", fwd_hit1, fwd_data1); else passCnt++;
    step();
    #1;
    totalCnt++; if (count !== 3'd0) $display("FAIL single_drained: got %0d want 0", count); else passCnt++;
  endtask

  task automatic test_forward_full();
    port_free = 1'b0; in_valid = 1'b1;
    in_reg = 5'd3; in_data = 32'd1; step();
    in_reg = 5'd3; in_data = 32'd2; step();
    in_valid = 1'b0; ReadReg2 = 5'd3;
    #1;
    totalCnt++; if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'd2)
      $display("FAIL fwd_youngest: got %b/%h want 1/2", fwd_hit2, fwd_data2); else passCnt++;
    in_valid = 1'b1;
    in_reg = 5'd9;  in_data = 32'hA; step();
    in_reg = 5'd10; in_data = 32'hB; step();
    #1;
    totalCnt++; if (count !== 3'd4) $display("FAIL full_count: got %0d want 4", count); else passCnt++;
    totalCnt++; if (in_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", in_ready); else passCnt++;
  endtask

  task automatic test_drain_wrap();
    logic [4:0] got[$];
    logic [4:0] want[6];
    want = '{5'd3, 5'd3, 5'd9, 5'd10, 5'd11, 5'd12};
    port_free = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in_valid = (c < 3);
      in_reg   = (c < 2) ? 5'd11 : 5'd12;
      in_data  = 32'h100 + c;
      #1;
      if (c == 0) begin
        totalCnt++; if (in_ready !== 1'b0) $display("FAIL drain_ready0: got %b want 0", in_ready); else passCnt++;
      end
      if (c == 1) begin
        totalCnt++; if (in_ready !== 1'b1) $display("FAIL drain_ready1: got %b want 1", in_ready); else passCnt++;
      end
      if (RegWriteEN === 1'b1) got.push_back(WriteReg);
      step();
    end
    in_valid = 1'b0;
    totalCnt++; if (got.size() !== 6) $display("FAIL wrap_len: got %0d want 6", got.size()); else passCnt++;
    for (int i = 0; i < 6; i++) begin
      if (i < got.size()) begin
        totalCnt++; if (got[i] !== want[i])
          $display("FAIL wrap_order[%0d]: got %0d want %0d", i, got[i], want[i]); else passCnt++;
      end
    end
  endtask

  task automatic test_zero_reg();
    port_free = 1'b1; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    in_valid = 1'b1; in_reg = 5'd0; in_data = 32'hFFFF_FFFF;
    #1;
    totalCnt++; if (in_ready !== 1'b1) $display("FAIL r0_ready: got %b want 1", in_ready); else passCnt++;
    step();
    in_valid = 1'b0;
    #1;
    totalCnt++; if (count !== 3'd0) $display("FAIL r0_count: got %0d want 0", count); else passCnt++;
    totalCnt++; if (RegWriteEN !== 1'b0) $display("FAIL r0_wen: got %b want 0", RegWriteEN); else passCnt++;
    totalCnt++; if (fwd_hit1 !== 1'b0 || fwd_hit2 !== 1'b0)
      $display("FAIL r0_fwd: got %b%b want 00", fwd_hit1, fwd_hit2); else passCnt++;
  endtask

  task automatic test_reset_mid();
    port_free = 1'b0; in_valid = 1'b1;
    in_reg = 5'd1; in_data = 32'h11; step();
    in_reg = 5'd2; in_data = 32'h22; step();
    in_reg = 5'd4; in_data = 32'h44; step();
    in_valid = 1'b0;
    #1;
    totalCnt++; if (count !== 3'd3) $display("FAIL pend_count: got %0d want 3", count); else passCnt++;
    #2;
    rst = 1'b1; mq.delete();
    #1;
    totalCnt++; if (count !== 3'd0) $display("FAIL pulse_count: got %0d want 0", count); else passCnt++;
    @(negedge clk);
    rst = 1'b0; port_free = 1'b1; ReadReg1 = 5'd1;
    #1;
    totalCnt++; if (RegWriteEN !== 1'b0) $display("FAIL pulse_wen: got %b want 0", RegWriteEN); else passCnt++;
    totalCnt++; if (fwd_hit1 !== 1'b0) $display("FAIL pulse_fwd: got %b want 0", fwd_hit1); else passCnt++;
    step();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      in_reg    = 5'($urandom_range(0, 7));
      in_data   = $urandom;
      port_free = ($urandom_range(0, 99) < 45);
      ReadReg1  = 5'($urandom_range(0, 7));
      ReadReg2  = 5'($urandom_range(0, 7));
      #1;
      totalCnt++; if (count !== 3'(mq.size()))
        $display("FAIL rnd_count c%0d: got %0d want %0d", c, count, mq.size()); else passCnt++;
      totalCnt++; if (in_ready !== (mq.size() != 4))
        $display("FAIL rnd_ready c%0d: got %b want %b", c, in_ready, mq.size() != 4); else passCnt++;
      totalCnt++; if (RegWriteEN !== (port_free && mq.size() != 0))
        $display("FAIL rnd_wen c%0d: got %b", c, RegWriteEN); else passCnt++;
      totalCnt++; if (WriteReg !== ((mq.size() != 0) ? mq[0].r : 5'd0))
        $display("FAIL rnd_wreg c%0d: got %0d", c, WriteReg); else passCnt++;
      totalCnt++; if (WriteData !== ((mq.size() != 0) ? mq[0].d : 32'd0))
        $display("FAIL rnd_wdata c%0d: got %h", c, WriteData); else passCnt++;
      totalCnt++; if (fwd_hit1 !== mhit(ReadReg1))
        $display("FAIL rnd_hit1 c%0d: got %b want %b", c, fwd_hit1, mhit(ReadReg1)); else passCnt++;
      totalCnt++; if (fwd_data1 !== mdata(ReadReg1))
        $display("FAIL rnd_data1 c%0d: got %h want %h", c, fwd_data1, mdata(ReadReg1)); else passCnt++;
      totalCnt++; if (fwd_hit2 !== mhit(ReadReg2))
        $display("FAIL rnd_hit2 c%0d: got %b want %b", c, fwd_hit2, mhit(ReadReg2)); else passCnt++;
      totalCnt++; if (fwd_data2 !== mdata(ReadReg2))
        $display("FAIL rnd_data2 c%0d: got %h want %h", c, fwd_data2, mdata(ReadReg2)); else passCnt++;
      step();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_reg = '0; in_data = '0; port_free = 1'b0;
    ReadReg1 = '0; ReadReg2 = '0;
    test_reset();
    test_single();
    test_forward_full();
    test_drain_wrap();
    test_zero_reg();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
